// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and access sequencer for a single-port data memory
//
// Purpose:
//   Arbitrates between a CPU load/store port (port 0) and a debug/loader
//   port (port 1) in front of a word-addressed data memory. The memory has
//   a synchronous write and a combinational read. Each granted transaction
//   runs IDLE -> ACCESS -> RESP, which is exactly three cycles. There is no
//   pipelining. The response carries registered read data or an error.
//
// Configuration:
//   ARB_FIXED_PRIO_EN - when defined, port 0 always wins simultaneous
//                       requests and the round-robin pointer is removed.
//                       When undefined (the default), simultaneous requests
//                       are served round-robin.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pN_valid/pN_ready      request handshake; ready pulses in IDLE only
//   pN_we/addr/wdata       request: write flag, byte address, write data
//   pN_rvalid              one-cycle response pulse, granted port only
//   pN_rdata/pN_err        response data and error; held between responses
//   mem_addr/wdata         memory address and write data; 0 outside ACCESS
//   mem_write/mem_read     memory strobes; asserted only during ACCESS
//   mem_rdata              combinational read data from the memory
//   busy                   FSM is not in IDLE

module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,

  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,

  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [31:0]   mem_rdata,

  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;

  // Latched request of the transaction in flight.
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          id_q, id_d;

  // Each port has its own response registers. A response to one port
  // therefore never disturbs the held values seen by the other port.
  logic [31:0]   p0_rdata_q, p0_rdata_d;
  logic [31:0]   p1_rdata_q, p1_rdata_d;
  logic          p0_err_q, p0_err_d;
  logic          p1_err_q, p1_err_d;

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin pointer: names the port that wins the next tie.
  logic          rr_q, rr_d;
`endif

  logic          grant;
  logic          win;
  logic          acc_err;
  logic [31:0]   rsp_data;
  logic          mem_write_raw;

  // ---------------------------------------------------------------------
  // Arbitration. A grant happens only in IDLE and only when a port is
  // valid. It is suppressed while rst is high, so ready stays low then.
  // ---------------------------------------------------------------------
  always_comb begin
    grant = (state_q == S_IDLE) && (p0_valid || p1_valid) && !rst;
`ifdef ARB_FIXED_PRIO_EN
    win = !p0_valid;
`else
    if (p0_valid && p1_valid) begin
      win = rr_q;
    end else begin
      win = !p0_valid;
    end
`endif
  end

  assign p0_ready = grant && !win;
  assign p1_ready = grant &&  win;

  // A request is in error if it is misaligned or beyond the end of memory.
  // The word index is zero-extended to AW bits so the comparison against
  // DEPTH stays unsigned and matches in width.
  always_comb begin
    acc_err = (addr_q[1:0] != 2'b00) ||
              ({2'b00, addr_q[AW-1:2]} >= AW'(DEPTH));
  end

  // ---------------------------------------------------------------------
  // Next-state logic, memory strobes and response loading.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    id_d          = id_q;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    p0_err_d      = p0_err_q;
    p1_err_d      = p1_err_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_d          = rr_q;
`endif
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_write_raw = 1'b0;
    mem_read      = 1'b0;
    rsp_data      = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          id_d    = win;
          we_d    = win ? p1_we    : p0_we;
          addr_d  = win ? p1_addr  : p0_addr;
          wdata_d = win ? p1_wdata : p0_wdata;
`ifndef ARB_FIXED_PRIO_EN
          // The loser gets priority on the next tie.
          rr_d    = !win;
`endif
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (!acc_err) begin
          mem_addr      = 32'(addr_q);
          mem_wdata     = wdata_q;
          mem_write_raw = we_q;
          mem_read      = !we_q;
        end
        // Writes and errored accesses both return zero data.
        rsp_data = (acc_err || we_q) ? 32'h0 : mem_rdata;
        if (id_q) begin
          p1_rdata_d = rsp_data;
          p1_err_d   = acc_err;
        end else begin
          p0_rdata_d = rsp_data;
          p0_err_d   = acc_err;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A reset arriving during ACCESS must not let the write commit on the
  // same edge, so the strobe is masked directly by rst.
  assign mem_write = mem_write_raw && !rst;

  assign p0_rvalid = (state_q == S_RESP) && !id_q;
  assign p1_rvalid = (state_q == S_RESP) &&  id_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  assign busy      = (state_q != S_IDLE);

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      id_q       <= 1'b0;
      p0_rdata_q <= 32'h0;
      p1_rdata_q <= 32'h0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      id_q       <= id_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      p0_err_q   <= p0_err_d;
      p1_err_q   <= p1_err_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port request arbiter and access sequencer in front of the single-port data memory (word-addressed via addr[31:2], synchronous write, combinational read).
- Port 0 is the CPU load/store path; port 1 is the debug/loader path.
- Arbitrates between the ports, drives the memory's MemRead/MemWrite/addr/WriteData, and returns registered read data or an error response to the winning requester.

Parameters:
DEPTH, 1024, number of 32-bit words in the memory behind the arbiter; word index >= DEPTH is out of range.
AW, 32, byte-address width of both request ports.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
p0_valid  input  1  port 0 request valid.
p0_ready  output  1  port 0 request accepted this cycle.
p0_we  input  1  port 0 write (1) / read (0).
p0_addr  input  AW  port 0 byte address.
p0_wdata  input  32  port 0 write data.
p0_rvalid  output  1  port 0 response pulse.
p0_rdata  output  32  port 0 read data; valid with p0_rvalid.
p0_err  output  1  port 0 response error; valid with p0_rvalid.
p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rvalid, p1_rdata, p1_err  same as the port 0 signals, for port 1.
mem_addr  output  32  address to the memory.
mem_wdata  output  32  write data to the memory.
mem_write  output  1  memory write enable.
mem_read  output  1  memory read enable.
mem_rdata  input  32  combinational read data from the memory.
busy  output  1  high in any state other than IDLE.

Behaviour:
Reset state:
- All outputs 0; FSM in IDLE; round-robin pointer = 0, so port 0 has priority.
- Synchronous reset in any state returns the FSM to IDLE and drops the in-flight transaction.
- No response is issued for a dropped transaction.
- mem_write is gated with ~rst, so no write commits on an edge where rst = 1.

FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each transaction takes exactly 3 cycles; no pipelining.

IDLE:
- If any pN_valid is high, select a winner.
- If only one port is valid, it wins.
- If both are valid, the port named by the pointer wins.
- pN_ready = 1 for the winner, combinationally, in this cycle only.
- On the edge: latch we, addr, wdata and the port id; go to ACCESS.
- The pointer then points at the loser.
- Ready never asserts outside IDLE.

Request handshake:
- A requester holds valid, we, addr and wdata stable until ready.
- Valid deasserting before ready is legal; the request is simply withdrawn.

ACCESS:
- Compute err = (latched addr[1:0] != 0) or (addr[31:2] >= DEPTH).
- If err = 0: mem_addr = latched addr; mem_wdata = latched wdata; mem_write = we; mem_read = ~we.
- A write commits at the end of ACCESS.
- For a read, mem_rdata is captured into the response register at the end of ACCESS.
- If err = 1: mem_read and mem_write stay 0, and the response register is loaded with 0.
- Go to RESP.

RESP:
- pN_rvalid = 1 for exactly one cycle, for the granted port only.
- pN_rdata = the captured data for a read, 0 for a write.
- pN_err = err.
- Go to IDLE.

Idle-state memory signals:
- Outside ACCESS, mem_read, mem_write, mem_addr and mem_wdata are all 0.
- Memory read data is therefore 0 when idle.

Response hold:
- pN_rdata and pN_err hold their last values between responses.
- They are meaningful only while pN_rvalid = 1.

Optional Feature:
Macro ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests, and the pointer is removed. Port 1 may starve while port 0 requests back-to-back.
- Undefined (default): round-robin as described above; each port waits at most one other transaction.

Test Plan:
1. Reset, then p0 write addr 0x10 data 0xDEADBEEF. Expect p0_ready in cycle 0, mem_write = 1 with mem_addr = 0x10 in cycle 1, p0_rvalid = 1 with p0_err = 0 in cycle 2. Then p0 read 0x10 -> p0_rdata = 0xDEADBEEF.
2. p0 and p1 both reading continuously, with preloaded word 0 = 0x1 and word 1 = 0x2 (p0 addr 0x0, p1 addr 0x4). Expect grants alternating p0, p1, p0, p1, one grant every 3 cycles. With ARB_FIXED_PRIO_EN defined, p0 only.
3. p1 write to addr 0x6 (misaligned). Expect no mem_write in any cycle, p1_rvalid = 1, p1_err = 1, p1_rdata = 0. Memory word 1 is unchanged.
4. p0 read at addr 0x1000 (word 1024 >= DEPTH). Expect p0_err = 1, mem_read never asserted, p0_rdata = 0.
5. rst asserted during ACCESS of a p0 write to 0x20 data 0x55. Expect the memory word at 0x20 to be unchanged, no p0_rvalid, and busy = 0 and the FSM in IDLE on the next cycle.
6. p0_valid pulses 1 cycle during p1's RESP and then drops. Expect no p0_ready, no memory access, and no p0 response.
